register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised successor to the single-cycle core's 2R/1W register file.
- Adds a second writeback port, for a separate load/long-latency return path, and write-to-read bypass.
- Adds a per-register busy scoreboard so the decode stage can detect RAW hazards, plus a registered count of outstanding destinations.
- Sits between decode/issue and the writeback stage; register x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- NUM_REGS, 32, number of architectural registers (power of two, >= 2).
- ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override).
- BYPASS_EN, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads see stored array only.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rs1_addr  input  ADDR_W  read port 1 address
- rs2_addr  input  ADDR_W  read port 2 address
- rs1_data  output  DATA_WIDTH  read port 1 data (combinational)
- rs2_data  output  DATA_WIDTH  read port 2 data (combinational)
- rs1_busy  output  1  rs1 has an outstanding pending write
- rs2_busy  output  1  rs2 has an outstanding pending write
- iss_en  input  1  issue strobe: mark iss_rd busy
- iss_rd  input  ADDR_W  destination register being issued
- wb0_en  input  1  writeback port 0 enable (ALU path)
- wb0_addr  input  ADDR_W  writeback port 0 address
- wb0_data  input  DATA_WIDTH  writeback port 0 data
- wb1_en  input  1  writeback port 1 enable (load path)
- wb1_addr  input  ADDR_W  writeback port 1 address
- wb1_data  input  DATA_WIDTH  writeback port 1 data
- busy_count  output  ADDR_W+1  registered number of busy registers

Behaviour:
- Reset (rst=1, async):
  - All registers cleared to 0; all busy bits cleared; busy_count=0.
  - Reset mid-operation discards pending writes; no write occurs on a clock edge while rst=1.
- Writes:
  - On a clk rising edge, wbN_en=1 with wbN_addr!=0 writes wbN_data into reg[wbN_addr].
  - Writes to x0 are ignored.
  - Both ports enabled to the same address: wb1 wins (it carries the younger result).
- Reads (combinational, zero latency):
  - rsN_addr==0 -> data 0, busy 0.
  - BYPASS_EN=1 and a same-cycle write targets rsN_addr (nonzero): data = that write data, wb1 having priority over wb0.
  - Otherwise data = reg[rsN_addr].
- Scoreboard (busy[NUM_REGS-1:1]; busy[0] constant 0):
  - Next busy[r] = (busy[r] & ~clr[r]) | set[r].
  - set[r] = iss_en & iss_rd==r & r!=0.
  - clr[r] = (wb0_en & wb0_addr==r) | (wb1_en & wb1_addr==r).
  - Set and clear of the same register in one cycle -> busy stays 1 (new producer pending).
  - Writeback to a non-busy register is legal: data written, busy unchanged at 0.
- rsN_busy:
  - BYPASS_EN=1: busy[rsN_addr] & ~clr[rsN_addr], because data is being forwarded this cycle.
  - BYPASS_EN=0: busy[rsN_addr] & ~(clr[rsN_addr] & 0), i.e. plain busy bit; the consumer stalls one cycle after writeback.
  - Same-cycle issue does not affect rsN_busy (takes effect next cycle).
- busy_count:
  - Registered population count of the next-state busy vector, updated each edge; equals the number of busy bits after the edge.
  - Range 0..NUM_REGS-1; never wraps.
- No handshake back-pressure; the caller guarantees at most one issue per cycle.

Decomposition:
- Shared package regfile_pkg: default DATA_WIDTH/NUM_REGS constants and the x0 index constant ZERO_REG=0.
- One natural sub-module: popcount (parametrised width-in, count-out combinational adder tree) used for busy_count.
- Storage array, bypass muxing and scoreboard stay in the top module.

Test Plan:
- Reset: load regs via wb0, then pulse rst=1 asynchronously mid-cycle -> all reads 0, busy 0, busy_count 0 immediately, without waiting for a clock edge.
- x0 protection: wb0 addr 0 data 0xDEADBEEF, iss_rd=0 -> rs1_addr=0 reads 0, rs1_busy=0, busy_count=0.
- Dual-write collision: wb0 (5, 0x11111111) and wb1 (5, 0x22222222) same edge -> reg5 = 0x22222222. Same cycle with rs1_addr=5 and BYPASS_EN=1 -> rs1_data = 0x22222222.
- Scoreboard: issue rd=7 -> next cycle rs2_addr=7 gives rs2_busy=1, busy_count=1. Cycle with wb1 (7, 0xA5A5A5A5) -> rs2_busy=0 and rs2_data=0xA5A5A5A5 that cycle; busy_count=0 after the edge.
- Set/clear race: reg3 busy; issue rd=3 and wb0 addr 3 same edge -> busy[3] stays 1, busy_count unchanged at 1, reg3 holds written data.
- BYPASS_EN=0 build: wb0 (9, 0x5) with rs1_addr=9 same cycle -> rs1_data = old value 0; value 0x5 appears the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared constants for the scoreboarded register file.
//          DEF_DATA_WIDTH - default register / data-port width
//          DEF_NUM_REGS   - default architectural register count
//          ZERO_REG       - index of the hardwired-zero register (x0)
// Rev    : 1.0  initial release
// ============================================================================
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int ZERO_REG       = 0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/register_file_sb_popcount.sv
`default_nettype none
// ============================================================================
// Module : popcount
// Brief  : Combinational population count built as a balanced adder tree.
//          The vector is split in halves recursively; every level works at
//          the full output width so no intermediate truncation can occur.
// Ports  : bits_i  [WIDTH-1:0]  input vector
//          count_o [CNT_W-1:0]  number of set bits in bits_i
// Rev    : 1.0  initial release
// ============================================================================
module popcount #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [CNT_W-1:0] count_o
);

  if (WIDTH == 1) begin : g_leaf
    assign count_o = CNT_W'(bits_i);
  end else begin : g_node
    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    logic [CNT_W-1:0] lo_cnt;
    logic [CNT_W-1:0] hi_cnt;

    popcount #(
      .WIDTH (LO_W),
      .CNT_W (CNT_W)
    ) u_lo (
      .bits_i  (bits_i[LO_W-1:0]),
      .count_o (lo_cnt)
    );

    popcount #(
      .WIDTH (HI_W),
      .CNT_W (CNT_W)
    ) u_hi (
      .bits_i  (bits_i[WIDTH-1:LO_W]),
      .count_o (hi_cnt)
    );

    assign count_o = lo_cnt + hi_cnt;
  end

endmodule : popcount
`default_nettype wire

// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
// Module : register_file_sb
// Brief  : 2-read / 2-write register file with write-to-read bypass and a
//          per-register busy scoreboard for RAW hazard detection. x0 is
//          hardwired to zero and can never be marked busy.
// Ports  : clk, rst                 clock, async active-high reset
//          rs1_addr/rs2_addr        read addresses
//          rs1_data/rs2_data        combinational read data
//          rs1_busy/rs2_busy        pending-write flags for the read regs
//          iss_en/iss_rd            issue strobe, marks iss_rd busy
//          wb0_en/addr/data         writeback port 0 (ALU path)
//          wb1_en/addr/data         writeback port 1 (load path, wins ties)
//          busy_count               registered number of busy registers
// Rev    : 1.0  initial release
// ============================================================================
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     rs1_addr,
  input  logic [ADDR_W-1:0]     rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_rd,
  input  logic                  wb0_en,
  input  logic [ADDR_W-1:0]     wb0_addr,
  input  logic [DATA_WIDTH-1:0] wb0_data,
  input  logic                  wb1_en,
  input  logic [ADDR_W-1:0]     wb1_addr,
  input  logic [DATA_WIDTH-1:0] wb1_data,
  output logic [ADDR_W:0]       busy_count
);

  localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [ADDR_W:0]       busy_count_q;
  logic [ADDR_W:0]       busy_count_d;

  // Per-register decode of the two writeback ports and the issue port.
  // Index 0 is never decoded, which keeps x0 unwritable and never busy.
  logic [NUM_REGS-1:0] wr0_hit;
  logic [NUM_REGS-1:0] wr1_hit;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set;

  always_comb begin
    wr0_hit = '0;
    wr1_hit = '0;
    set     = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      wr0_hit[r] = wb0_en && (wb0_addr == ADDR_W'(r));
      wr1_hit[r] = wb1_en && (wb1_addr == ADDR_W'(r));
      set[r]     = iss_en && (iss_rd == ADDR_W'(r));
    end
  end

  assign clr = wr0_hit | wr1_hit;

  // A new producer issued in the same cycle as the old one retires keeps
  // the register busy: set dominates clear.
  always_comb begin
    busy_d    = (busy_q & ~clr) | set;
    busy_d[0] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Storage array. Entry 0 is only ever reset, so it stays zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr1_hit[r]) begin
          regs_q[r] <= wb1_data;
        end else if (wr0_hit[r]) begin
          regs_q[r] <= wb0_data;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard and outstanding-destination counter
  // --------------------------------------------------------------------------
  popcount #(
    .WIDTH (NUM_REGS),
    .CNT_W (ADDR_W + 1)
  ) u_popcount (
    .bits_i  (busy_d),
    .count_o (busy_count_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  // --------------------------------------------------------------------------
  // Read ports (combinational)
  // --------------------------------------------------------------------------
  logic [1:0][ADDR_W-1:0]     rd_addr;
  logic [1:0][DATA_WIDTH-1:0] rd_data;
  logic [1:0]                 rd_busy;

  assign rd_addr = {rs2_addr, rs1_addr};

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < 2; p++) begin
      if (rd_addr[p] != C_ZERO_ADDR) begin
        rd_data[p] = regs_q[rd_addr[p]];
        rd_busy[p] = busy_q[rd_addr[p]];
        if (BYPASS_EN) begin
          // Forwarded data resolves the hazard this cycle, so the busy flag
          // is masked by the matching writeback.
          if (wr1_hit[rd_addr[p]]) begin
            rd_data[p] = wb1_data;
          end else if (wr0_hit[rd_addr[p]]) begin
            rd_data[p] = wb0_data;
          end
          rd_busy[p] = busy_q[rd_addr[p]] & ~clr[rd_addr[p]];
        end
      end
    end
  end

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];
  assign rs1_busy = rd_busy[0];
  assign rs2_busy = rd_busy[1];

endmodule : register_file_sb
`default_nettype wire

// File: tb/tb_register_file_sb.sv
`default_nettype none
// ============================================================================
// Module : tb_register_file_sb
// Brief  : Scoreboard bench for register_file_sb. Two instances share every
//          input: one with bypass, one without. Stimulus pushes expected
//          values tagged with the cycle number; a negedge monitor pops and
//          compares them against the selected DUT output.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_register_file_sb;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rs1_addr, rs2_addr, iss_rd, wb0_addr, wb1_addr;
  logic [DW-1:0] wb0_data, wb1_data;
  logic          iss_en, wb0_en, wb1_en;

  logic [DW-1:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic          rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
  logic [AW:0]   busy_count, nb_busy_count;

  always #5 clk = ~clk;

  register_file_sb #(
    .DATA_WIDTH (DW), .NUM_REGS (NR), .BYPASS_EN (1'b1)
  ) u_dut (
    .clk (clk), .rst (rst),
    .rs1_addr (rs1_addr), .rs2_addr (rs2_addr),
    .rs1_data (rs1_data), .rs2_data (rs2_data),
    .rs1_busy (rs1_busy), .rs2_busy (rs2_busy),
    .iss_en (iss_en), .iss_rd (iss_rd),
    .wb0_en (wb0_en), .wb0_addr (wb0_addr), .wb0_data (wb0_data),
    .wb1_en (wb1_en), .wb1_addr (wb1_addr), .wb1_data (wb1_data),
    .busy_count (busy_count)
  );

  register_file_sb #(
    .DATA_WIDTH (DW), .NUM_REGS (NR), .BYPASS_EN (1'b0)
  ) u_dut_nb (
    .clk (clk), .rst (rst),
    .rs1_addr (rs1_addr), .rs2_addr (rs2_addr),
    .rs1_data (nb_rs1_data), .rs2_data (nb_rs2_data),
    .rs1_busy (nb_rs1_busy), .rs2_busy (nb_rs2_busy),
    .iss_en (iss_en), .iss_rd (iss_rd),
    .wb0_en (wb0_en), .wb0_addr (wb0_addr), .wb0_data (wb0_data),
    .wb1_en (wb1_en), .wb1_addr (wb1_addr), .wb1_data (wb1_data),
    .busy_count (nb_busy_count)
  );

  typedef enum int {
    K_RS1D, K_RS1B, K_RS2D, K_RS2B, K_CNT,
    K_NB_RS1D, K_NB_RS1B, K_NB_RS2D, K_NB_RS2B, K_NB_CNT
  } kind_e;

  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(kind_e k);
    case (k)
      K_RS1D:    return rs1_data;
      K_RS1B:    return {31'b0, rs1_busy};
      K_RS2D:    return rs2_data;
      K_RS2B:    return {31'b0, rs2_busy};
      K_CNT:     return 32'(busy_count);
      K_NB_RS1D: return nb_rs1_data;
      K_NB_RS1B: return {31'b0, nb_rs1_busy};
      K_NB_RS2D: return nb_rs2_data;
      K_NB_RS2B: return {31'b0, nb_rs2_busy};
      default:   return 32'(nb_busy_count);
    endcase
  endfunction

  // Monitor: compare everything queued for the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e   = sb_q.pop_front();
      act = actual(e.kind);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s cyc %0d actual %h required %h", e.name, cyc, act, e.exp);
      end
    end
  end

  task automatic expect_v(kind_e k, logic [31:0] v, string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.exp  = v;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    iss_en = 1'b0; iss_rd = '0;
    wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_en = 1'b0; wb1_addr = '0; wb1_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wb0(logic [AW-1:0] a, logic [DW-1:0] d);
    wb0_en = 1'b1; wb0_addr = a; wb0_data = d;
  endtask

  task automatic wb1(logic [AW-1:0] a, logic [DW-1:0] d);
    wb1_en = 1'b1; wb1_addr = a; wb1_data = d;
  endtask

  task automatic issue(logic [AW-1:0] rd);
    iss_en = 1'b1; iss_rd = rd;
  endtask

  initial begin
    idle();
    rs1_addr = '0;
    rs2_addr = '0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Post-reset state
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    expect_v(K_RS1D, 32'h0, "rst_rs1d");
    expect_v(K_RS1B, 32'h0, "rst_rs1b");
    expect_v(K_CNT,  32'h0, "rst_cnt");

    // Load r1/r2 on both ports, issue r4; bypass visible same cycle
    step();
    wb0(5'd1, 32'h1111_0001); wb1(5'd2, 32'h2222_0002); issue(5'd4);
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    expect_v(K_RS1D,    32'h1111_0001, "byp_wb0");
    expect_v(K_RS2D,    32'h2222_0002, "byp_wb1");
    expect_v(K_NB_RS1D, 32'h0,         "nb_no_byp");

    step();
    rs1_addr = 5'd1; rs2_addr = 5'd4;
    expect_v(K_NB_RS1D, 32'h1111_0001, "nb_stored_r1");
    expect_v(K_RS2B,    32'h1,         "r4_busy");
    expect_v(K_CNT,     32'h1,         "cnt_r4");

    // Asynchronous reset mid-cycle, checked before the next rising edge
    step();
    rst = 1'b1;
    rs1_addr = 5'd4; rs2_addr = 5'd1;
    expect_v(K_RS1B, 32'h0, "arst_busy");
    expect_v(K_RS2D, 32'h0, "arst_data");
    expect_v(K_CNT,  32'h0, "arst_cnt");

    // x0 protection
    step();
    rst = 1'b0;
    wb0(5'd0, 32'hDEAD_BEEF); issue(5'd0);
    rs1_addr = 5'd0; rs2_addr = 5'd2;
    expect_v(K_RS1D, 32'h0, "x0_data");
    expect_v(K_RS1B, 32'h0, "x0_busy");
    expect_v(K_RS2D, 32'h0, "r2_after_rst");

    step();
    rs1_addr = 5'd0;
    expect_v(K_RS1D,   32'h0, "x0_data_next");
    expect_v(K_CNT,    32'h0, "x0_cnt");
    expect_v(K_NB_CNT, 32'h0, "x0_nb_cnt");

    // Dual-write collision: wb1 wins
    step();
    wb0(5'd5, 32'h1111_1111); wb1(5'd5, 32'h2222_2222);
    rs1_addr = 5'd5;
    expect_v(K_RS1D,    32'h2222_2222, "coll_byp");
    expect_v(K_NB_RS1D, 32'h0,         "coll_nb_old");

    step();
    issue(5'd7);
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    expect_v(K_RS1D,    32'h2222_2222, "coll_stored");
    expect_v(K_NB_RS1D, 32'h2222_2222, "coll_nb_stored");
    expect_v(K_RS2B,    32'h0,         "iss_same_cycle");

    // Scoreboard set/clear
    step();
    rs2_addr = 5'd7;
    expect_v(K_RS2B,    32'h1, "r7_busy");
    expect_v(K_NB_RS2B, 32'h1, "r7_nb_busy");
    expect_v(K_CNT,     32'h1, "r7_cnt");

    step();
    wb1(5'd7, 32'hA5A5_A5A5);
    rs2_addr = 5'd7;
    expect_v(K_RS2B,    32'h0,         "r7_wb_busy");
    expect_v(K_RS2D,    32'hA5A5_A5A5, "r7_wb_data");
    expect_v(K_NB_RS2B, 32'h1,         "r7_nb_wb_busy");
    expect_v(K_NB_RS2D, 32'h0,         "r7_nb_wb_data");
    expect_v(K_CNT,     32'h1,         "r7_wb_cnt");

    step();
    issue(5'd3);
    rs2_addr = 5'd7;
    expect_v(K_CNT,     32'h0,         "r7_clr_cnt");
    expect_v(K_RS2D,    32'hA5A5_A5A5, "r7_stored");
    expect_v(K_NB_RS2B, 32'h0,         "r7_nb_clr");

    // Set/clear race on r3
    step();
    issue(5'd3); wb0(5'd3, 32'h3333_3333);
    rs1_addr = 5'd3;
    expect_v(K_RS1B,    32'h0,         "race_byp_busy");
    expect_v(K_NB_RS1B, 32'h1,         "race_nb_busy");
    expect_v(K_RS1D,    32'h3333_3333, "race_byp_data");
    expect_v(K_CNT,     32'h1,         "race_cnt_before");

    step();
    rs1_addr = 5'd3;
    expect_v(K_RS1B,    32'h1,         "race_busy_kept");
    expect_v(K_NB_RS1B, 32'h1,         "race_nb_busy_kept");
    expect_v(K_RS1D,    32'h3333_3333, "race_data");
    expect_v(K_NB_RS1D, 32'h3333_3333, "race_nb_data");
    expect_v(K_CNT,     32'h1,         "race_cnt");
    expect_v(K_NB_CNT,  32'h1,         "race_nb_cnt");

    // No-bypass build sees the old value for one cycle
    step();
    wb0(5'd9, 32'h0000_0005); wb1(5'd3, 32'h0000_0044);
    rs1_addr = 5'd9;
    expect_v(K_NB_RS1D, 32'h0,         "nb_r9_old");
    expect_v(K_RS1D,    32'h0000_0005, "byp_r9");

    step();
    rs1_addr = 5'd9;
    expect_v(K_NB_RS1D, 32'h0000_0005, "nb_r9_new");
    expect_v(K_CNT,     32'h0,         "final_cnt");
    expect_v(K_NB_CNT,  32'h0,         "final_nb_cnt");

    step();
    step();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual %0d pending required 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_register_file_sb
`default_nettype wire
